stream_fifo_lvl: RTL and testbench
==================================

# stream_fifo_lvl

Parametrised successor to the single-clock HWPE-Stream FIFO: buffers `{data, strb}` beats between a stream sink and a stream source. It supports arbitrary (non-power-of-two) depth, an exact occupancy counter, programmable almost-full/almost-empty thresholds, a peak-occupancy watermark, and an optional first-word fall-through path. It sits between TCDM request/response stream stages wherever a decoupling buffer needs back-pressure headroom signalling.

## Interface
- `DATA_WIDTH`, 32, payload width; strobe width is `(DATA_WIDTH+7)/8`.
- `FIFO_DEPTH`, 8, number of entries; any value ≥ 2, not restricted to powers of two.
- `ALMOST_FULL_TH`, `FIFO_DEPTH-1`, `almost_full` asserts when `level ≥ ALMOST_FULL_TH`; legal range 1..`FIFO_DEPTH`.
- `ALMOST_EMPTY_TH`, 1, `almost_empty` asserts when `level ≤ ALMOST_EMPTY_TH`; legal range 0..`FIFO_DEPTH-1`.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `clear_i` in 1: synchronous clear, with the same effect as reset.
- `push_i` in/out `stream_intf.sink`: input stream carrying `data`, `strb`, `valid`, `ready`.
- `pop_o` in/out `stream_intf.source`: output stream.
- `flags_o` out `flags_fifo_lvl_t`: `empty`, `full`, `almost_full`, `almost_empty`, `level`, `peak_level`, `push_pointer`, `pop_pointer`.
- `LW = $clog2(FIFO_DEPTH+1)` gives the width of `level` and `peak_level`.
- `AW = $clog2(FIFO_DEPTH)` gives the pointer width.

## Operation
- Storage is `FIFO_DEPTH` registers of `DATA_WIDTH+(DATA_WIDTH+7)/8` bits, laid out as `{data, strb}`.
- Push fires on `push_i.valid & push_i.ready`. Pop fires on `pop_o.valid & pop_o.ready`.
- `push_i.ready = !full`. It is registered-state only and never depends on `pop_o.ready`, so there is no combinational ready path. A full FIFO therefore refuses a push even in a cycle that also pops.
- `pop_o.valid = !empty` (fall-through extension: see Configuration).
- `pop_o.data` and `pop_o.strb` show the entry at `pop_pointer`, and are forced to `'0` while `pop_o.valid = 0`.
- Pointers increment modulo `FIFO_DEPTH` by an explicit compare to `FIFO_DEPTH-1` followed by a wrap to 0. Power-of-two overflow is never relied on.
- The `level` update rule:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- `empty = (level == 0)`, `full = (level == FIFO_DEPTH)`. Both are derived from the registered level, so there is no separate FSM.
- `peak_level` is a register that loads `level_d` whenever `level_d > peak_level`. It only ever increases until reset or `clear_i`.
- Reset or `clear_i` (when both are active, reset wins) sets all of the following; storage contents are also zeroed:
  - level = 0, peak = 0, both pointers = 0.
  - `empty = 1`, `almost_empty = 1`, `full = 0`.
  - `almost_full = (ALMOST_FULL_TH == 0)`, which is 0 for legal parameters.
  - `push_i.ready = 1`, `pop_o.valid = 0`.
- While `clear_i` is high, pushes are ignored regardless of the handshake, and `clear_i` takes priority over a simultaneous push or pop.
- Reset asserted mid-burst discards all contents immediately (asynchronously). The first push after deassertion writes entry 0.

## Timing
- Without fall-through, latency is 1 cycle: a beat pushed at edge N is visible on `pop_o` after edge N.
- Throughput is 1 beat/cycle in steady state whenever 0 < level < `FIFO_DEPTH`.
- All flags are registered-state functions and update on the edge following the handshake.
- `peak_level` reflects a new maximum on the same edge at which `level` reaches it.

## Configuration
- Macro: `STREAM_FIFO_LVL_FALL_THROUGH_EN`.
- Defined:
  - When `empty` and `push_i.valid`, the push beat is presented combinationally on `pop_o` with `pop_o.valid = 1`.
  - If `pop_o.ready` is also high, the beat bypasses storage: level, pointers, and peak all stay unchanged.
  - Otherwise it is written normally.
  - This adds a combinational path from `push_i` to `pop_o` and gives 0-cycle latency.
- Undefined:
  - No bypass, and `pop_o` is driven from registered state only.

## Structure
- `mem_pkg` holds the following:
  - `flags_fifo_lvl_t`, a packed struct with `empty`, `full`, `almost_full`, `almost_empty`, `level[7:0]`, `peak_level[7:0]`, `push_pointer[7:0]`, `pop_pointer[7:0]`. Narrower values are zero-extended.
  - A function `fifo_lvl_width(depth)` returning `$clog2(depth+1)`.
- Parameter legality is checked by elaboration-time assertions: `FIFO_DEPTH ≥ 2`, and both thresholds within their legal ranges.
- No sub-module is required.
- The pointer/level control is a natural candidate for `fifo_lvl_ctrl`: pointers, level, and peak, with storage kept in the top.

## Test plan
- Reset, then 8 pushes of 0x1000_0000+i with `pop_o.ready = 0` and DEPTH=8. Required:
  - `full = 1` after the 8th edge and `push_i.ready = 0`.
  - A 9th push is refused.
  - `level = 8`, `peak_level = 8`.
- DEPTH=5 (non-power-of-two), 12 beats streamed with `pop_o.ready` toggling 1010…. Required:
  - Output order is identical to input order.
  - Pointers wrap 4→0.
  - `level` never exceeds 5.
- Thresholds `ALMOST_FULL_TH = 6`, `ALMOST_EMPTY_TH = 2`; fill 0→8, then drain. Required:
  - `almost_full` rises at level 6 and falls when level returns to 5.
  - `almost_empty` is high at levels 0–2.
- Level 3 with push and pop in the same cycle for 10 cycles. Required:
  - `level` stays at 3 and `peak_level` stays at 3.
  - Output data lags input by exactly 3 beats.
- At level 4, assert `clear_i` together with a push. Required:
  - Next cycle: `level = 0`, `peak_level = 0`, `empty = 1`, `pop_o.data = 0`.
  - The pushed beat is lost.
  - Repeat with `rst_ni` pulsed mid-cycle: outputs reset immediately.
- With `STREAM_FIFO_LVL_FALL_THROUGH_EN` defined, empty FIFO, push 0xDEADBEEF with `pop_o.ready = 1`. Required:
  - The same-cycle `pop_o.valid = 1` with data 0xDEADBEEF.
  - Level and peak remain 0.
  - With the macro undefined, the data appears one cycle later and `peak_level = 1`.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and helpers for the level-tracking stream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef struct packed {
        logic       empty;
        logic       full;
        logic       almost_full;
        logic       almost_empty;
        logic [7:0] level;
        logic [7:0] peak_level;
        logic [7:0] push_pointer;
        logic [7:0] pop_pointer;
    } flags_fifo_lvl_t;

    function automatic int fifo_lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo_lvl_ctrl.sv
// ============================================================================
// Module   : stream_fifo_lvl_ctrl
// Brief    : Pointer, occupancy and peak-occupancy tracking for stream_fifo_lvl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo_lvl_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int LW         = 4,
    parameter int AW         = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          write_i,
    input  logic          read_i,
    output logic [AW-1:0] push_ptr_o,
    output logic [AW-1:0] pop_ptr_o,
    output logic [LW-1:0] level_o,
    output logic [LW-1:0] peak_o
);

    logic [AW-1:0] r_push_ptr;
    logic [AW-1:0] r_pop_ptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] r_peak;
    logic [LW-1:0] w_level_d;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(FIFO_DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    always_comb begin
        w_level_d = r_level;
        if (write_i && !read_i) begin
            w_level_d = r_level + LW'(1);
        end else if (!write_i && read_i) begin
            w_level_d = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_push_ptr <= '0;
            r_pop_ptr  <= '0;
            r_level    <= '0;
            r_peak     <= '0;
        end else if (clear_i) begin
            r_push_ptr <= '0;
            r_pop_ptr  <= '0;
            r_level    <= '0;
            r_peak     <= '0;
        end else begin
            if (write_i) begin
                r_push_ptr <= ptr_inc(r_push_ptr);
            end
            if (read_i) begin
                r_pop_ptr <= ptr_inc(r_pop_ptr);
            end
            r_level <= w_level_d;
            if (w_level_d > r_peak) begin
                r_peak <= w_level_d;
            end
        end
    end

    assign push_ptr_o = r_push_ptr;
    assign pop_ptr_o  = r_pop_ptr;
    assign level_o    = r_level;
    assign peak_o     = r_peak;

endmodule

`default_nettype wire

// File: rtl/stream_fifo_lvl.sv
// ============================================================================
// Module   : stream_fifo_lvl
// Brief    : Single-clock {data,strb} stream FIFO with exact level, thresholds
//            and peak watermark. STREAM_FIFO_LVL_FALL_THROUGH_EN adds bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo_lvl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic [DATA_WIDTH-1:0]       push_data_i,
    input  logic [(DATA_WIDTH+7)/8-1:0] push_strb_i,
    input  logic                        push_valid_i,
    output logic                        push_ready_o,
    output logic [DATA_WIDTH-1:0]       pop_data_o,
    output logic [(DATA_WIDTH+7)/8-1:0] pop_strb_o,
    output logic                        pop_valid_o,
    input  logic                        pop_ready_i,
    output flags_fifo_lvl_t             flags_o
);

    localparam int c_strb_w  = (DATA_WIDTH + 7) / 8;
    localparam int c_entry_w = DATA_WIDTH + c_strb_w;
    localparam int c_lw      = fifo_lvl_width(FIFO_DEPTH);
    localparam int c_aw      = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("stream_fifo_lvl: FIFO_DEPTH must be at least 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_chk_af
        $error("stream_fifo_lvl: ALMOST_FULL_TH out of range 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > FIFO_DEPTH - 1) begin : g_chk_ae
        $error("stream_fifo_lvl: ALMOST_EMPTY_TH out of range 0..FIFO_DEPTH-1");
    end

    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];

    logic [c_aw-1:0]      w_push_ptr;
    logic [c_aw-1:0]      w_pop_ptr;
    logic [c_lw-1:0]      w_level;
    logic [c_lw-1:0]      w_peak;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop_valid;
    logic                 w_bypass;
    logic                 w_push_hs;
    logic                 w_pop_hs;
    logic                 w_write;
    logic                 w_read;
    logic [c_entry_w-1:0] w_pop_entry;

    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == c_lw'(FIFO_DEPTH));

    // Ready looks only at registered occupancy: a full FIFO refuses even while popping.
    assign push_ready_o = !w_full;

`ifdef STREAM_FIFO_LVL_FALL_THROUGH_EN
    assign w_pop_valid = !w_empty || push_valid_i;
    assign w_bypass    = w_empty && push_valid_i && pop_ready_i;
`else
    assign w_pop_valid = !w_empty;
    assign w_bypass    = 1'b0;
`endif

    assign w_push_hs = push_valid_i && !w_full && !clear_i;
    assign w_pop_hs  = w_pop_valid && pop_ready_i && !clear_i;
    // A bypassed beat is consumed straight from the input; storage is untouched.
    assign w_write   = w_push_hs && !w_bypass;
    assign w_read    = w_pop_hs && !w_bypass;

    stream_fifo_lvl_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LW         (c_lw),
        .AW         (c_aw)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .write_i    (w_write),
        .read_i     (w_read),
        .push_ptr_o (w_push_ptr),
        .pop_ptr_o  (w_pop_ptr),
        .level_o    (w_level),
        .peak_o     (w_peak)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[w_push_ptr] <= {push_data_i, push_strb_i};
        end
    end

    always_comb begin
        w_pop_entry = r_mem[w_pop_ptr];
`ifdef STREAM_FIFO_LVL_FALL_THROUGH_EN
        if (w_empty) begin
            w_pop_entry = {push_data_i, push_strb_i};
        end
`endif
        if (!w_pop_valid) begin
            w_pop_entry = '0;
        end
    end

    assign {pop_data_o, pop_strb_o} = w_pop_entry;
    assign pop_valid_o              = w_pop_valid;

    always_comb begin
        flags_o              = '0;
        flags_o.empty        = w_empty;
        flags_o.full         = w_full;
        flags_o.almost_full  = (w_level >= c_lw'(ALMOST_FULL_TH));
        flags_o.almost_empty = (w_level <= c_lw'(ALMOST_EMPTY_TH));
        flags_o.level        = 8'(w_level);
        flags_o.peak_level   = 8'(w_peak);
        flags_o.push_pointer = 8'(w_push_ptr);
        flags_o.pop_pointer  = 8'(w_pop_ptr);
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_fifo_lvl.sv
// ============================================================================
// Module   : tb_stream_fifo_lvl
// Brief    : Directed scoreboard bench driving a depth-8 and a depth-5 FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_fifo_lvl;
    import mem_pkg::*;

    localparam int DEP [2] = '{8, 5};
    localparam int AFT [2] = '{6, 4};
    localparam int AET [2] = '{2, 1};
`ifdef STREAM_FIFO_LVL_FALL_THROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        clear      = 1'b0;
    logic        push_valid = 1'b0;
    logic        pop_ready  = 1'b0;
    logic [31:0] push_data  = '0;
    logic [3:0]  push_strb  = '0;

    logic            push_ready_o [2];
    logic            pop_valid_o  [2];
    logic [31:0]     pop_data_o   [2];
    logic [3:0]      pop_strb_o   [2];
    flags_fifo_lvl_t flags        [2];

    int          lvl [2];
    int          pk  [2];
    int          wp  [2];
    int          rp  [2];
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_fifo_lvl #(
        .DATA_WIDTH (32), .FIFO_DEPTH (8), .ALMOST_FULL_TH (6), .ALMOST_EMPTY_TH (2)
    ) u_a (
        .clk_i (clk), .rst_ni (rst_n), .clear_i (clear),
        .push_data_i (push_data), .push_strb_i (push_strb), .push_valid_i (push_valid),
        .push_ready_o (push_ready_o[0]),
        .pop_data_o (pop_data_o[0]), .pop_strb_o (pop_strb_o[0]), .pop_valid_o (pop_valid_o[0]),
        .pop_ready_i (pop_ready), .flags_o (flags[0])
    );

    stream_fifo_lvl #(
        .DATA_WIDTH (32), .FIFO_DEPTH (5)
    ) u_b (
        .clk_i (clk), .rst_ni (rst_n), .clear_i (clear),
        .push_data_i (push_data), .push_strb_i (push_strb), .push_valid_i (push_valid),
        .push_ready_o (push_ready_o[1]),
        .pop_data_o (pop_data_o[1]), .pop_strb_o (pop_strb_o[1]), .pop_valid_o (pop_valid_o[1]),
        .pop_ready_i (pop_ready), .flags_o (flags[1])
    );

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [35:0] q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic q_push(input int k, input logic [35:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            lvl[k] = 0; pk[k] = 0; wp[k] = 0; rp[k] = 0;
        end
    endtask

    task automatic chk_state();
        for (int k = 0; k < 2; k++) begin
            chk("level",        k, flags[k].level,        lvl[k]);
            chk("peak_level",   k, flags[k].peak_level,   pk[k]);
            chk("empty",        k, flags[k].empty,        lvl[k] == 0);
            chk("full",         k, flags[k].full,         lvl[k] == DEP[k]);
            chk("almost_full",  k, flags[k].almost_full,  lvl[k] >= AFT[k]);
            chk("almost_empty", k, flags[k].almost_empty, lvl[k] <= AET[k]);
            chk("push_pointer", k, flags[k].push_pointer, wp[k]);
            chk("pop_pointer",  k, flags[k].pop_pointer,  rp[k]);
        end
    endtask

    // One clock cycle: drive, check the pre-edge handshake view, clock, update model, check state.
    task automatic cyc(input logic pv, input logic [31:0] d, input logic pr, input logic clr);
        logic        dp [2];
        logic        dq [2];
        logic        by [2];
        logic        exp_v;
        logic [35:0] exp_d;
        push_valid = pv;
        push_data  = d;
        push_strb  = d[3:0];
        pop_ready  = pr;
        clear      = clr;
        #1;
        for (int k = 0; k < 2; k++) begin
            by[k] = FT && (lvl[k] == 0) && pv;
            exp_v = (lvl[k] > 0) || by[k];
            exp_d = !exp_v ? 36'h0 : ((lvl[k] > 0) ? q_front(k) : {d, d[3:0]});
            chk("push_ready", k, push_ready_o[k], lvl[k] < DEP[k]);
            chk("pop_valid",  k, pop_valid_o[k],  exp_v);
            chk("pop_beat",   k, {pop_data_o[k], pop_strb_o[k]}, exp_d);
            dp[k] = pv && (lvl[k] < DEP[k]) && !clr;
            dq[k] = pr && exp_v && !clr;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                if (k == 0) q0.delete(); else q1.delete();
                lvl[k] = 0; pk[k] = 0; wp[k] = 0; rp[k] = 0;
            end else if (!(by[k] && dq[k])) begin
                if (dq[k]) begin
                    q_pop(k);
                    rp[k] = (rp[k] == DEP[k] - 1) ? 0 : rp[k] + 1;
                end
                if (dp[k]) begin
                    q_push(k, {d, d[3:0]});
                    wp[k] = (wp[k] == DEP[k] - 1) ? 0 : wp[k] + 1;
                end
                lvl[k] = lvl[k] + int'(dp[k]) - int'(dq[k]);
                if (lvl[k] > pk[k]) pk[k] = lvl[k];
            end
        end
        chk_state();
    endtask

    // Reset pulse well away from any clock edge; effects must be visible at once.
    task automatic pulse_rst();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        clear      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_push_ready", k, push_ready_o[k], 1'b1);
            chk("rst_pop_valid",  k, pop_valid_o[k],  1'b0);
            chk("rst_pop_beat",   k, {pop_data_o[k], pop_strb_o[k]}, 36'h0);
        end
        chk_state();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("init_push_ready", k, push_ready_o[k], 1'b1);
            chk("init_pop_valid",  k, pop_valid_o[k],  1'b0);
        end
        chk_state();
        rst_n = 1'b1;

        // Fill to full with the sink stalled, then a refused extra beat.
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0);
        cyc(1'b1, 32'hBAD0_0009, 1'b0, 1'b0);
        repeat (9) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming with an alternating sink; depth 5 exercises the 4->0 wrap.
        for (int i = 0; i < 12; i++) cyc(1'b1, 32'h2000_0000 + i, (i % 2) == 0, 1'b0);
        repeat (9) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Clear, reach level 3, then steady push+pop.
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)  cyc(1'b1, 32'h3000_0000 + i, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h3100_0000 + i, 1'b1, 1'b0);

        // Clear at level 4 with a concurrent push: beat lost.
        cyc(1'b1, 32'h3200_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h3300_0000, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Mid-cycle reset, then the next beat must land in entry 0.
        cyc(1'b1, 32'h3400_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h3400_0001, 1'b0, 1'b0);
        pulse_rst();
        cyc(1'b1, 32'h4000_0000, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Empty FIFO with both sides ready: bypass or one-cycle latency.
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
